// File: rtl/irda_rx_data_ctrl_if.sv
// RX FIFO write port: the MIR/FIR RX data controller is the master, the RX FIFO the slave.
interface irda_rx_data_ctrl_if #(
    parameter int FIFO_POINTER_W = 4
);
    logic                    rxfifo_add;
    logic [31:0]             rxfifo_dat_i;
    logic [FIFO_POINTER_W:0] rxfifo_count;

    modport master (
        output rxfifo_add,
        output rxfifo_dat_i,
        input  rxfifo_count
    );

    modport slave (
        input  rxfifo_add,
        input  rxfifo_dat_i,
        output rxfifo_count
    );
endinterface

// File: rtl/irda_rx_data_ctrl.sv
// MIR/FIR RX data controller: packs received bits LSB-first into 32-bit words for the RX FIFO.
// Optional macro IRDA_RX_BIT_COUNT_EN adds the rx_bit_count output (accepted bits per frame).
module irda_rx_data_ctrl #(
    parameter int FIFO_POINTER_W = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       wb_rst_i,
    input  logic                       rc_restart,
    input  logic                       rc_restart_fir,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    input  logic                       frame_end,
    input  logic                       mir_mode,
    input  logic                       fir_mode,
    input  logic                       mir_rxbit_enable,
    input  logic                       fir_rx4_enable,
    irda_rx_data_ctrl_if.master        fifo,
    output logic                       rx_overrun,
    output logic                       frame_done,
    output logic [4:0]                 last_bits,
    output logic                       rx_busy
`ifdef IRDA_RX_BIT_COUNT_EN
    ,
    output logic [15:0]                rx_bit_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FLUSH
    } state_t;

    state_t      state;
    logic [31:0] sr;
    logic [4:0]  sr_p;
    logic        flush_pend;

    logic acc;
    logic restart;
    logic fifo_full;
    logic wr_slot;

    assign acc       = bit_valid && ((mir_mode && mir_rxbit_enable) ||
                                     (fir_mode && fir_rx4_enable));
    assign restart   = rc_restart || rc_restart_fir;
    assign fifo_full = (fifo.rxfifo_count >= (FIFO_POINTER_W + 1)'(FIFO_DEPTH));

    // The write strobe is decoded from the state so a restart arriving in the
    // WRITE/FLUSH cycle can still suppress it before the FIFO samples it.
    assign wr_slot           = (state == WRITE) || ((state == FLUSH) && (sr_p != 5'd0));
    assign fifo.rxfifo_add   = wr_slot && !fifo_full && !restart;
    assign fifo.rxfifo_dat_i = sr;
    assign rx_busy           = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // branch and the synchronous restart branch clear exactly the same state.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            sr         <= '0;
            sr_p       <= '0;
            flush_pend <= 1'b0;
            rx_overrun <= 1'b0;
            frame_done <= 1'b0;
            last_bits  <= '0;
        end else if (restart) begin
            state      <= IDLE;
            sr         <= '0;
            sr_p       <= '0;
            flush_pend <= 1'b0;
            rx_overrun <= 1'b0;
            frame_done <= 1'b0;
            last_bits  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        sr[sr_p] <= bit_in;
                        sr_p     <= sr_p + 5'd1;
                        state    <= frame_end ? FLUSH : COLLECT;
                    end else if (frame_end) begin
                        frame_done <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (acc) begin
                        sr[sr_p] <= bit_in;
                        sr_p     <= sr_p + 5'd1;
                        if (sr_p == 5'd31) begin
                            state      <= WRITE;
                            flush_pend <= frame_end;
                        end else if (frame_end) begin
                            state <= FLUSH;
                        end
                    end else if (frame_end) begin
                        state <= FLUSH;
                    end
                end

                WRITE: begin
                    if (fifo_full) begin
                        rx_overrun <= 1'b1;
                    end
                    sr         <= '0;
                    flush_pend <= 1'b0;
                    // A frame_end landing on the WRITE cycle itself is not lost.
                    state      <= (flush_pend || frame_end) ? FLUSH : COLLECT;
                end

                FLUSH: begin
                    if ((sr_p != 5'd0) && fifo_full) begin
                        rx_overrun <= 1'b1;
                    end
                    last_bits  <= sr_p;
                    frame_done <= 1'b1;
                    sr         <= '0;
                    sr_p       <= '0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef IRDA_RX_BIT_COUNT_EN
    // Counts only bits the FSM actually stores; bits dropped in WRITE/FLUSH are excluded.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_bit_count <= '0;
        end else if (restart) begin
            rx_bit_count <= '0;
        end else if (acc && ((state == IDLE) || (state == COLLECT))) begin
            if (state == IDLE) begin
                rx_bit_count <= 16'd1;
            end else if (rx_bit_count != 16'hFFFF) begin
                rx_bit_count <= rx_bit_count + 16'd1;
            end
        end
    end
`endif

    // The RX FIFO accepts at most one word per cycle pair from this block.
    assert property (@(posedge clk) disable iff (wb_rst_i)
        fifo.rxfifo_add |=> !fifo.rxfifo_add);

endmodule

// File: tb/tb_irda_rx_data_ctrl.sv
// Scoreboard bench for irda_rx_data_ctrl: directed frames push expected words/last_bits, a monitor pops and compares.
module tb_irda_rx_data_ctrl;

    localparam int PW = 4;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       rc_restart;
    logic       rc_restart_fir;
    logic       bit_valid;
    logic       bit_in;
    logic       frame_end;
    logic       mir_mode;
    logic       fir_mode;
    logic       mir_rxbit_enable;
    logic       fir_rx4_enable;
    logic       rx_overrun;
    logic       frame_done;
    logic [4:0] last_bits;
    logic       rx_busy;
`ifdef IRDA_RX_BIT_COUNT_EN
    logic [15:0] rx_bit_count;
`endif

    irda_rx_data_ctrl_if #(.FIFO_POINTER_W(PW)) fifo_if ();

    irda_rx_data_ctrl #(.FIFO_POINTER_W(PW), .FIFO_DEPTH(16)) dut (
        .clk              (clk),
        .wb_rst_i         (wb_rst_i),
        .rc_restart       (rc_restart),
        .rc_restart_fir   (rc_restart_fir),
        .bit_valid        (bit_valid),
        .bit_in           (bit_in),
        .frame_end        (frame_end),
        .mir_mode         (mir_mode),
        .fir_mode         (fir_mode),
        .mir_rxbit_enable (mir_rxbit_enable),
        .fir_rx4_enable   (fir_rx4_enable),
        .fifo             (fifo_if),
        .rx_overrun       (rx_overrun),
        .frame_done       (frame_done),
        .last_bits        (last_bits),
        .rx_busy          (rx_busy)
`ifdef IRDA_RX_BIT_COUNT_EN
        ,
        .rx_bit_count     (rx_bit_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          add_cyc  = -100;
    int          done_cyc = -100;
    bit          use_fir  = 1'b0;
    logic        prev_add = 1'b0;
    logic [31:0] exp_words[$];
    logic [4:0]  exp_last[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard whenever the DUT writes the FIFO or ends a frame.
    always @(negedge clk) begin
        if (!wb_rst_i) begin
            if (fifo_if.rxfifo_add) begin
                check("add_back_to_back", {31'd0, prev_add}, 32'd0);
                add_cyc = cyc;
                if (exp_words.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got %h expected no write", fifo_if.rxfifo_dat_i);
                end else begin
                    check("rxfifo_dat_i", fifo_if.rxfifo_dat_i, exp_words.pop_front());
                end
            end
            if (frame_done) begin
                done_cyc = cyc;
                if (exp_last.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done: got last_bits %0d expected no frame_done", last_bits);
                end else begin
                    check("last_bits", {27'd0, last_bits}, {27'd0, exp_last.pop_front()});
                end
            end
        end
        prev_add = fifo_if.rxfifo_add;
    end

    task automatic send_bit(input logic b, input logic fe);
        @(posedge clk); #1;
        bit_valid = 1'b1;
        bit_in    = b;
        frame_end = fe;
        if (use_fir) fir_rx4_enable = 1'b1;
        else         mir_rxbit_enable = 1'b1;
        @(posedge clk); #1;
        bit_valid        = 1'b0;
        bit_in           = 1'b0;
        frame_end        = 1'b0;
        fir_rx4_enable   = 1'b0;
        mir_rxbit_enable = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic end_frame;
        @(posedge clk); #1 frame_end = 1'b1;
        @(posedge clk); #1 frame_end = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_restart(input bit fir);
        @(posedge clk); #1;
        if (fir) rc_restart_fir = 1'b1;
        else     rc_restart = 1'b1;
        @(posedge clk); #1;
        rc_restart     = 1'b0;
        rc_restart_fir = 1'b0;
    endtask

    initial begin
        wb_rst_i = 1'b1;  rc_restart = 1'b0;  rc_restart_fir = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0;      frame_end = 1'b0;
        mir_mode = 1'b1;  fir_mode = 1'b0;
        mir_rxbit_enable = 1'b0; fir_rx4_enable = 1'b0;
        fifo_if.rxfifo_count = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_add",        {31'd0, fifo_if.rxfifo_add}, 32'd0);
        check("rst_dat",        fifo_if.rxfifo_dat_i,        32'd0);
        check("rst_overrun",    {31'd0, rx_overrun},         32'd0);
        check("rst_frame_done", {31'd0, frame_done},         32'd0);
        check("rst_last_bits",  {27'd0, last_bits},          32'd0);
        check("rst_busy",       {31'd0, rx_busy},            32'd0);
        @(posedge clk); #1 wb_rst_i = 1'b0;

        // 1: two full words, frame ends on a word boundary
        exp_words.push_back(32'hA5A5A5A5);
        exp_words.push_back(32'h0000FFFF);
        exp_last.push_back(5'd0);
        send_word(32'hA5A5A5A5, 32);
        send_word(32'h0000FFFF, 32);
        @(negedge clk);
        check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
        end_frame();
`ifdef IRDA_RX_BIT_COUNT_EN
        check("bit_count_64", {16'd0, rx_bit_count}, 32'd64);
`endif

        // 2: 40 bits -> zero-padded partial word, last_bits=8
        exp_words.push_back(32'h12345678);
        exp_words.push_back(32'h0000003C);
        exp_last.push_back(5'd8);
        send_word(32'h12345678, 32);
        send_word(32'h0000003C, 8);
        end_frame();

        // 3: FIFO full while a word completes -> dropped, sticky overrun
        fifo_if.rxfifo_count = 5'd16;
        exp_last.push_back(5'd0);
        send_word(32'hDEADBEEF, 32);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("overrun_set", {31'd0, rx_overrun}, 32'd1);
        end_frame();
        fifo_if.rxfifo_count = 5'd3;
        exp_words.push_back(32'h00000081);
        exp_last.push_back(5'd8);
        send_word(32'h00000081, 8);
        end_frame();
        check("overrun_sticky", {31'd0, rx_overrun}, 32'd1);
        exp_last.push_back(5'd8);
        end_frame();
        pulse_restart(1'b0);
        @(negedge clk);
        check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);
        check("restart_last_bits", {27'd0, last_bits}, 32'd0);

        // 4: FIR mode without the 4PPM strobe accepts nothing
        mir_mode = 1'b0; fir_mode = 1'b1; use_fir = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b1; bit_in = 1'b1; mir_rxbit_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fir_gated_busy", {31'd0, rx_busy}, 32'd0);
        end
        @(posedge clk); #1;
        bit_valid = 1'b0; bit_in = 1'b0; mir_rxbit_enable = 1'b0;
        exp_words.push_back(32'h0000000A);
        exp_last.push_back(5'd4);
        send_word(32'h0000000A, 4);
        end_frame();

        // 5: restart during the WRITE cycle cancels the write
        send_word(32'hCAFEF00D, 31);
        @(posedge clk); #1;
        bit_valid = 1'b1; bit_in = 1'b1; fir_rx4_enable = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0; bit_in = 1'b0; fir_rx4_enable = 1'b0;
        rc_restart_fir = 1'b1;
        @(negedge clk);
        check("restart_write_add", {31'd0, fifo_if.rxfifo_add}, 32'd0);
        @(posedge clk); #1 rc_restart_fir = 1'b0;
        @(negedge clk);
        check("restart_busy",      {31'd0, rx_busy},            32'd0);
        check("restart_dat",       fifo_if.rxfifo_dat_i,        32'd0);
        check("restart_last_bits", {27'd0, last_bits},          32'd0);
        check("restart_done",      {31'd0, frame_done},         32'd0);

        // 6: 32nd bit together with frame_end -> one write, frame_done two cycles later
        exp_words.push_back(32'h80000001);
        exp_last.push_back(5'd0);
        send_word(32'h80000001, 31);
        send_bit(1'b1, 1'b1);
        repeat (6) @(posedge clk);
        check("done_after_write", done_cyc - add_cyc, 32'd2);

        repeat (4) @(posedge clk);
        check("words_drained", exp_words.size(), 32'd0);
        check("frames_drained", exp_last.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
